game_motion_ctrl: RTL

GAME_MOTION_CTRL -- requirements
Module: game_motion_ctrl

---
 rtl/game_motion_ctrl_if.sv | 26 ++
 rtl/game_motion_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/game_motion_ctrl_if.sv
// Signal bundle between the sync/graphic generators, player controls and the motion controller.
// master drives scan position and controls; slave (the controller) drives ball/paddle state.
interface game_motion_ctrl_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       start;
    logic       btn_up;
    logic       btn_down;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] bar_y_t;
    logic       playing;
    logic       miss;
    logic [7:0] score;
    logic [1:0] dbg_state;  // 0 = IDLE, 1 = PLAY, 2 = MISS

    modport master (
        output pixel_x, pixel_y, start, btn_up, btn_down,
        input  ball_x, ball_y, bar_y_t, playing, miss, score, dbg_state
    );

    modport slave (
        input  pixel_x, pixel_y, start, btn_up, btn_down,
        output ball_x, ball_y, bar_y_t, playing, miss, score, dbg_state
    );
endinterface

// File: rtl/game_motion_ctrl.sv
// Ball/paddle motion controller for a one-player wall game: frame-tick driven ball physics,
// paddle stepping, scoring, and an IDLE/PLAY/MISS game-state machine.
module game_motion_ctrl #(
    parameter int BALL_SIZE   = 8,
    parameter int BALL_V      = 2,
    parameter int BAR_H       = 72,
    parameter int BAR_V       = 4,
    parameter int BAR_X_L     = 600,
    parameter int BAR_X_R     = 603,
    parameter int WALL_X_R    = 35,
    parameter int MISS_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst,
    game_motion_ctrl_if.slave  bus
);

    localparam int CW = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

    localparam logic [9:0]  SERVE_X  = 10'd316;
    localparam logic [9:0]  SERVE_Y  = 10'd236;
    localparam logic [9:0]  BAR_INIT = 10'((480 - BAR_H) / 2);
    localparam logic [9:0]  BAR_MAX  = 10'(480 - BAR_H);
    localparam logic [9:0]  BAR_STEP = 10'(BAR_V);
    localparam logic [9:0]  BALL_STEP = 10'(BALL_V);

    // Geometry limits in 12 bits so ball+size sums never wrap in comparisons.
    localparam logic [11:0] TOP_LIM  = 12'(BALL_V);
    localparam logic [11:0] BOT_LIM  = 12'(480 - BALL_V);
    localparam logic [11:0] WALL_LIM = 12'(WALL_X_R + BALL_V + 1);
    localparam logic [11:0] MISS_LIM = 12'(639 - BALL_SIZE);
    localparam logic [11:0] PAD_L    = 12'(BAR_X_L);
    localparam logic [11:0] PAD_R    = 12'(BAR_X_R);
    localparam logic [11:0] SZ       = 12'(BALL_SIZE);
    localparam logic [11:0] SZ_M1    = 12'(BALL_SIZE - 1);
    localparam logic [11:0] BAR_H_M1 = 12'(BAR_H - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MISS_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_MISS = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          tick_cond, cond_q, tick;
    logic [9:0]    ball_x, ball_y, bar_y;
    logic          dx_neg, dy_neg;
    logic          dx_neg_d, dy_neg_d;
    logic [9:0]    ball_x_d, ball_y_d;
    logic          paddle_hit, off_right, miss_det;
    logic [7:0]    score;
    logic          miss_q;
    logic [CW-1:0] frame_cnt;
    logic [11:0]   bx, by, bar_e;

    assign bx    = {2'b00, ball_x};
    assign by    = {2'b00, ball_y};
    assign bar_e = {2'b00, bar_y};

    // Frame tick: one cycle, one clock after the start-of-vblank position first appears.
    assign tick_cond = (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd481);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cond_q <= 1'b0;
            tick   <= 1'b0;
        end else begin
            cond_q <= tick_cond;
            tick   <= tick_cond & ~cond_q;
        end
    end

    assign off_right = (bx > MISS_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        miss_det = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_PLAY;
            S_PLAY: begin
                if (tick && off_right) begin
                    state_d  = S_MISS;
                    miss_det = 1'b1;
                end
            end
            S_MISS: if (tick && (frame_cnt == CNT_LAST)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Ball physics for one frame, evaluated on the pre-move position and paddle row.
    always_comb begin
        dx_neg_d   = dx_neg;
        dy_neg_d   = dy_neg;
        paddle_hit = 1'b0;
        if (by <= TOP_LIM)          dy_neg_d = 1'b0;
        else if (by + SZ >= BOT_LIM) dy_neg_d = 1'b1;
        if (bx <= WALL_LIM) dx_neg_d = 1'b0;
        if (!dx_neg && (bx + SZ_M1 >= PAD_L) && (bx + SZ_M1 <= PAD_R) &&
            (by + SZ_M1 >= bar_e) && (by <= bar_e + BAR_H_M1)) begin
            dx_neg_d   = 1'b1;
            paddle_hit = 1'b1;
        end
        ball_x_d = dx_neg_d ? (ball_x - BALL_STEP) : (ball_x + BALL_STEP);
        ball_y_d = dy_neg_d ? (ball_y - BALL_STEP) : (ball_y + BALL_STEP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ball_x <= SERVE_X;
            ball_y <= SERVE_Y;
            dx_neg <= 1'b1;
            dy_neg <= 1'b0;
            score  <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ball_x <= SERVE_X;
                    ball_y <= SERVE_Y;
                    dx_neg <= 1'b1;
                    dy_neg <= 1'b0;
                    if (bus.start) score <= 8'd0;
                end
                S_PLAY: begin
                    if (tick && !off_right) begin
                        ball_x <= ball_x_d;
                        ball_y <= ball_y_d;
                        dx_neg <= dx_neg_d;
                        dy_neg <= dy_neg_d;
                        if (paddle_hit && (score != 8'hFF)) score <= score + 8'd1;
                    end
                end
                S_MISS: begin
                    if (state_d == S_IDLE) begin
                        ball_x <= SERVE_X;
                        ball_y <= SERVE_Y;
                        dx_neg <= 1'b1;
                        dy_neg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (state_q != S_MISS) begin
            frame_cnt <= '0;
        end else if (tick) begin
            frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) miss_q <= 1'b0;
        else      miss_q <= miss_det;
    end

    // Paddle steps in every game state; opposing buttons cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_y <= BAR_INIT;
        end else if (tick) begin
            if (bus.btn_up && !bus.btn_down)
                bar_y <= (bar_y < BAR_STEP) ? 10'd0 : bar_y - BAR_STEP;
            else if (bus.btn_down && !bus.btn_up)
                bar_y <= (bar_y > BAR_MAX - BAR_STEP) ? BAR_MAX : bar_y + BAR_STEP;
        end
    end

    assign bus.ball_x    = ball_x;
    assign bus.ball_y    = ball_y;
    assign bus.bar_y_t   = bar_y;
    assign bus.playing   = (state_q == S_PLAY);
    assign bus.miss      = miss_q;
    assign bus.score     = score;
    assign bus.dbg_state = state_q;

endmodule
